// File: rtl/uart_apb_arb.sv
// ---------------------------------------------------------------------------
// uart_apb_arb
//
// Two-master APB arbiter/sequencer in front of the UART register block.
// Port 0 is the CPU bridge, port 1 the RX-drain/TX-fill engine. Each
// granted transfer runs a fixed SETUP -> ACCESS -> DONE sequence because the
// UART slave has no pready. Arbitration is round-robin and happens in IDLE
// and DONE only.
//
// Optional feature macro: UART_ARB_LOCK_EN
//   When defined, an owner holding lock_i and req_i in DONE is re-granted
//   up to LOCK_MAX-1 consecutive times. When undefined, lock_i is ignored.
//
// Ports:
//   clk, rst_                 clock, asynchronous active-low reset
//   mN_req_i/write_i/addr_i/wdata_i/lock_i   requester N transfer request
//   mN_gnt_o                  one-cycle pulse in SETUP (request captured)
//   mN_done_o                 one-cycle pulse in DONE (transfer complete)
//   mN_rdata_o                read data, held until the next read on port N
//   paddr_o/pwdata_o/psel_o/penable_o/pwrite_o   APB master outputs
//   prdata_i                  APB read data
//   busy_o                    high in SETUP and ACCESS
// ---------------------------------------------------------------------------
module uart_apb_arb #(
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              m0_req_i,
    input  logic              m0_write_i,
    input  logic [3:0]        m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m0_lock_i,
    output logic              m0_gnt_o,
    output logic              m0_done_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_write_i,
    input  logic [3:0]        m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_done_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [3:0]        paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    input  logic [DATA_W-1:0] prdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic              last_q,    last_d;     // index of the most recent winner (= current owner)
    logic [1:0]        gnt_q,     gnt_d;
    logic [1:0]        done_q,    done_d;
    logic              psel_q,    psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q,  pwrite_d;
    logic              busy_q,    busy_d;
    logic [3:0]        paddr_q,   paddr_d;
    logic [DATA_W-1:0] pwdata_q,  pwdata_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              any_req_s;
    logic              win_s;

`ifdef UART_ARB_LOCK_EN
    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX - 1);

    logic [3:0]        lock_cnt_q, lock_cnt_d;
    logic              owner_req_s;
    logic              owner_lock_s;
    logic              lock_hold_s;

    assign owner_req_s  = last_q ? m1_req_i  : m0_req_i;
    assign owner_lock_s = last_q ? m1_lock_i : m0_lock_i;
`else
    // lock_i and LOCK_MAX have no function without the lock feature
    logic unused_lock_s;
    assign unused_lock_s = m0_lock_i ^ m1_lock_i ^ (LOCK_MAX > 0);
`endif

    assign any_req_s = m0_req_i | m1_req_i;

    // Arbitration: pick the winner among the current requests
    always_comb begin
        win_s = 1'b0;
        if (m0_req_i && m1_req_i) begin
            // tie goes to the port that did not win last time
            win_s = ~last_q;
        end else if (m1_req_i) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`ifdef UART_ARB_LOCK_EN
        lock_hold_s = 1'b0;
        if ((state_q == ST_DONE) && owner_req_s && owner_lock_s && (lock_cnt_q < LOCK_LIM)) begin
            lock_hold_s = 1'b1;
            win_s       = last_q;
        end else begin
            lock_hold_s = 1'b0;
        end
`endif
    end

    // Next-state and registered-output computation for the transfer sequencer
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        psel_d     = 1'b0;
        penable_d  = 1'b0;
        busy_d     = 1'b0;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef UART_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (any_req_s) begin
                    state_d  = ST_SETUP;
                    last_d   = win_s;
                    gnt_d    = win_s ? 2'b10 : 2'b01;
                    psel_d   = 1'b1;
                    busy_d   = 1'b1;
                    pwrite_d = win_s ? m1_write_i : m0_write_i;
                    paddr_d  = win_s ? m1_addr_i  : m0_addr_i;
                    pwdata_d = win_s ? m1_wdata_i : m0_wdata_i;
`ifdef UART_ARB_LOCK_EN
                    if (lock_hold_s) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                    end else begin
                        lock_cnt_d = 4'd0;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                busy_d    = 1'b1;
            end
            ST_ACCESS: begin
                // slave read data is valid at the end of ACCESS
                state_d = ST_DONE;
                done_d  = last_q ? 2'b10 : 2'b01;
                if (!pwrite_q && last_q) begin
                    m1_rdata_d = prdata_i;
                end else if (!pwrite_q) begin
                    m0_rdata_d = prdata_i;
                end else begin
                    m0_rdata_d = m0_rdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer immediately
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            busy_q     <= 1'b0;
            paddr_q    <= 4'd0;
            pwdata_q   <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_cnt_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            busy_q     <= busy_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef UART_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign m0_gnt_o   = gnt_q[0];
    assign m1_gnt_o   = gnt_q[1];
    assign m0_done_o  = done_q[0];
    assign m1_done_o  = done_q[1];
    assign m0_rdata_o = m0_rdata_q;
    assign m1_rdata_o = m1_rdata_q;
    assign paddr_o    = paddr_q;
    assign pwdata_o   = pwdata_q;
    assign psel_o     = psel_q;
    assign penable_o  = penable_q;
    assign pwrite_o   = pwrite_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_apb_arb.sv
module tb_uart_apb_arb;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_;
    logic              m0_req, m0_write, m0_lock, m1_req, m1_write, m1_lock;
    logic [3:0]        m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_gnt, m0_done, m1_gnt, m1_done;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [3:0]        paddr;
    logic [DATA_W-1:0] pwdata, prdata;
    logic              psel, penable, pwrite, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] slave_mem [16];
    logic [DATA_W-1:0] ref_mem   [16];
    logic [DATA_W-1:0] exp_rd    [2];
    int m_last;
    int m_streak;

    uart_apb_arb #(.DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_(rst_),
        .m0_req_i(m0_req), .m0_write_i(m0_write), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock),
        .m0_gnt_o(m0_gnt), .m0_done_o(m0_done), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_write_i(m1_write), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock),
        .m1_gnt_o(m1_gnt), .m1_done_o(m1_done), .m1_rdata_o(m1_rdata),
        .paddr_o(paddr), .pwdata_o(pwdata), .psel_o(psel), .penable_o(penable),
        .pwrite_o(pwrite), .prdata_i(prdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // APB slave: read data registered on the setup edge, writes on the access edge
    always @(posedge clk) begin
        if (psel && !penable) prdata <= slave_mem[paddr];
        if (psel && penable && pwrite) slave_mem[paddr] <= pwdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        m0_req = 1'b0; m0_write = 1'b0; m0_lock = 1'b0; m0_addr = 4'd0; m0_wdata = '0;
        m1_req = 1'b0; m1_write = 1'b0; m1_lock = 1'b0; m1_addr = 4'd0; m1_wdata = '0;
        #3;
        tick();
        tick();
        rst_ = 1'b1;
        m_last = 1; m_streak = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    // Reference arbitration: who should win given the requests present
    task automatic model_grant(input bit r0, input bit r1, input bit l0, input bit l1,
                               input bit from_done, output int w);
        bit held;
        held = 1'b0;
`ifdef UART_ARB_LOCK_EN
        if (from_done && ((m_last == 1) ? (r1 && l1) : (r0 && l0)) && (m_streak < LOCK_MAX - 1))
            held = 1'b1;
`endif
        if (held) begin
            w = m_last;
            m_streak = m_streak + 1;
        end else begin
            if (r0 && r1) w = 1 - m_last;
            else if (r1)  w = 1;
            else          w = 0;
            m_streak = 0;
        end
        m_last = w;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({psel, penable, pwrite, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {psel, penable, pwrite, busy});
        end
        n_tests++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 0000", {m0_gnt, m1_gnt, m0_done, m1_done});
        end
        n_tests++;
        if (paddr !== 4'd0 || pwdata !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            n_fail++; $display("FAIL reset_data: paddr=%h pwdata=%h r0=%h r1=%h want all 0",
                               paddr, pwdata, m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_read();
        int w;
        slave_mem[7] = 32'h0000_000A; ref_mem[7] = 32'h0000_000A;
        m0_write = 1'b0; m0_addr = 4'd7; m0_req = 1'b1;
        model_grant(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w);
        tick();
        n_tests++;
        if ({psel, penable, m0_gnt, busy} !== 4'b1011) begin
            n_fail++; $display("FAIL read_setup: psel/pen/gnt/busy=%b want 1011", {psel, penable, m0_gnt, busy});
        end
        m0_req = 1'b0;
        tick();
        n_tests++;
        if ({psel, penable, m0_done} !== 3'b110) begin
            n_fail++; $display("FAIL read_access: psel/pen/done=%b want 110", {psel, penable, m0_done});
        end
        tick();
        n_tests++;
        if ({psel, penable, m0_done, busy} !== 4'b0010 || m0_rdata !== 32'h0000_000A) begin
            n_fail++; $display("FAIL read_done: psel/pen/done/busy=%b rdata=%h want 0010 0000000a",
                               {psel, penable, m0_done, busy}, m0_rdata);
        end
        exp_rd[0] = 32'h0000_000A;
        tick();
    endtask

    task automatic test_write();
        int w;
        m1_write = 1'b1; m1_addr = 4'd0; m1_wdata = 32'h55; m1_req = 1'b1;
        model_grant(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, w);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) begin
                m1_req = 1'b0;
                n_tests++;
                if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
                    n_fail++; $display("FAIL write_gnt: m0/m1 gnt=%b%b want 01", m0_gnt, m1_gnt);
                end
            end
            n_tests++;
            if (pwrite !== 1'b1 || pwdata !== 32'h55 || paddr !== 4'd0) begin
                n_fail++; $display("FAIL write_bus c%0d: pwrite=%b pwdata=%h paddr=%h want 1 55 0",
                                   c, pwrite, pwdata, paddr);
            end
        end
        n_tests++;
        if (m1_done !== 1'b1 || m1_rdata !== exp_rd[1]) begin
            n_fail++; $display("FAIL write_done: done=%b rdata=%h want 1 %h", m1_done, m1_rdata, exp_rd[1]);
        end
        ref_mem[0] = 32'h55;
        tick();
        n_tests++;
        if (psel !== 1'b0 || pwdata !== 32'h55 || pwrite !== 1'b1) begin
            n_fail++; $display("FAIL write_idle_hold: psel=%b pwdata=%h pwrite=%b want 0 55 1", psel, pwdata, pwrite);
        end
    endtask

    task automatic test_back_to_back(input bit lk);
        int exp_ord [6];
        int got_ord [6];
        int stamp   [6];
        int k;
        int w;
        bit m1_seen;
        do_reset();
        m0_write = 1'b0; m1_write = 1'b0;
        m0_addr = 4'($urandom_range(1, 15)); m1_addr = 4'($urandom_range(1, 15));
        m0_lock = lk;
        m1_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            model_grant(1'b1, 1'b1, lk, 1'b0, (i > 0), w);
            exp_ord[i] = w;
            if (w == 1) m1_seen = 1'b1;
        end
        m0_req = 1'b1; m1_req = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            tick();
            if (m0_gnt && m1_gnt) begin
                n_tests++; n_fail++;
                $display("FAIL b2b_double_gnt: both grants high at cycle %0d", c);
            end
            if (m0_gnt || m1_gnt) begin
                got_ord[k] = m1_gnt ? 1 : 0;
                stamp[k] = c;
                k++;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0;
        n_tests++;
        if (k != 6) begin
            n_fail++; $display("FAIL b2b_count lock=%0d: got %0d grants want 6", lk, k);
        end
        for (int i = 0; i < k; i++) begin
            n_tests++;
            if (got_ord[i] != exp_ord[i]) begin
                n_fail++; $display("FAIL b2b_order lock=%0d #%0d: got port %0d want %0d", lk, i, got_ord[i], exp_ord[i]);
            end
            if (i > 0) begin
                n_tests++;
                if (stamp[i] - stamp[i-1] != 3) begin
                    n_fail++; $display("FAIL b2b_spacing #%0d: got %0d cycles want 3", i, stamp[i] - stamp[i-1]);
                end
            end
        end
        repeat (4) tick();
        exp_rd[0] = ref_mem[m0_addr];
        if (m1_seen) exp_rd[1] = ref_mem[m1_addr];
        n_tests++;
        if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
            n_fail++; $display("FAIL b2b_rdata: got %h %h want %h %h", m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        bit got1;
        int w;
        m0_write = 1'b0; m0_addr = 4'd3; m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        tick();
        n_tests++;
        if (penable !== 1'b1) begin
            n_fail++; $display("FAIL abort_in_access: penable=%b want 1", penable);
        end
        #2;
        rst_ = 1'b0;
        #1;
        n_tests++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            n_fail++; $display("FAIL abort_async: psel=%b penable=%b want 0 0", psel, penable);
        end
        m0_req = 1'b1; m1_req = 1'b1; m1_write = 1'b0; m1_addr = 4'd5;
        saw_done = 1'b0;
        repeat (2) begin
            tick();
            if (m0_done || m1_done) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++; $display("FAIL abort_no_done: done seen during reset, want none");
        end
        rst_ = 1'b1;
        m_last = 1; m_streak = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        model_grant(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, w);
        tick();
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b10 || w != 0) begin
            n_fail++; $display("FAIL abort_first_tie: m0/m1 gnt=%b%b want 10", m0_gnt, m1_gnt);
        end
        m0_req = 1'b0;
        model_grant(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, w);
        got1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (m1_gnt) begin
                m1_req = 1'b0; got1 = 1'b1;
            end
        end
        m1_req = 1'b0;
        n_tests++;
        if (!got1 || m0_rdata !== ref_mem[3] || m1_rdata !== ref_mem[5]) begin
            n_fail++; $display("FAIL abort_recover: m1 granted=%b r0=%h r1=%h want 1 %h %h",
                               got1, m0_rdata, m1_rdata, ref_mem[3], ref_mem[5]);
        end
        exp_rd[0] = ref_mem[3]; exp_rd[1] = ref_mem[5];
    endtask

    task automatic test_random(input int iters);
        logic [3:0]        a  [2];
        logic [DATA_W-1:0] d  [2];
        bit                wr [2];
        int                ep [2];
        logic [DATA_W-1:0] erd [2];
        int nreq, gi, di, w;
        bit r0, r1;
        int r;
        for (int it = 0; it < iters; it++) begin
            r = $urandom_range(1, 3);
            r0 = r[0]; r1 = r[1];
            for (int p = 0; p < 2; p++) begin
                a[p] = 4'($urandom_range(0, 15));
                d[p] = $urandom;
                wr[p] = ($urandom_range(0, 1) == 1);
            end
            nreq = (r0 && r1) ? 2 : 1;
            model_grant(r0, r1, 1'b0, 1'b0, 1'b0, w);
            ep[0] = w;
            if (nreq == 2) begin
                model_grant(w == 1, w == 0, 1'b0, 1'b0, 1'b1, w);
                ep[1] = w;
            end
            for (int i = 0; i < nreq; i++) begin
                if (wr[ep[i]]) ref_mem[a[ep[i]]] = d[ep[i]];
                else           exp_rd[ep[i]] = ref_mem[a[ep[i]]];
                erd[i] = exp_rd[ep[i]];
            end
            m0_write = wr[0]; m0_addr = a[0]; m0_wdata = d[0]; m0_req = r0;
            m1_write = wr[1]; m1_addr = a[1]; m1_wdata = d[1]; m1_req = r1;
            gi = 0; di = 0;
            for (int c = 0; c < 20 && di < nreq; c++) begin
                tick();
                if (m0_gnt || m1_gnt) begin
                    if (m0_gnt) m0_req = 1'b0;
                    if (m1_gnt) m1_req = 1'b0;
                    n_tests++;
                    if (gi >= nreq || (m0_gnt && m1_gnt) || (m1_gnt ? 1 : 0) != ep[gi]) begin
                        n_fail++; $display("FAIL rand_gnt it%0d: gnt=%b%b want port %0d", it, m1_gnt, m0_gnt,
                                           (gi < nreq) ? ep[gi] : -1);
                    end
                    gi++;
                end
                if (m0_done || m1_done) begin
                    n_tests++;
                    if (di >= nreq || (m0_done && m1_done) || (m1_done ? 1 : 0) != ep[di] ||
                        (m1_done ? m1_rdata : m0_rdata) !== erd[di]) begin
                        n_fail++; $display("FAIL rand_done it%0d: done=%b%b rdata=%h want port %0d rdata %h",
                                           it, m1_done, m0_done, m1_done ? m1_rdata : m0_rdata,
                                           (di < nreq) ? ep[di] : -1, (di < nreq) ? erd[di] : '0);
                    end
                    di++;
                end
            end
            m0_req = 1'b0; m1_req = 1'b0;
            if (di < nreq) begin
                n_tests++; n_fail++;
                $display("FAIL rand_timeout it%0d: got %0d dones want %0d", it, di, nreq);
            end
        end
        repeat (2) tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        do_reset();
        test_reset();
        test_read();
        test_write();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_abort();
        test_random(25);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_apb_arb.md
# uart_apb_arb

Two-master APB arbiter and sequencer placed in front of the UART register interface. It accepts single register transfers from two requesters (port 0: CPU bridge, port 1: RX-drain/TX-fill engine) and grants them round-robin. It drives each granted transfer as an APB setup phase followed by an access phase, then returns read data and a completion pulse to the owning requester. The UART slave has no `pready`, so every transfer has a fixed length.

## Interface
- `DATA_W`, 32: APB data width.
- `LOCK_MAX`, 4: maximum consecutive grants to one locking requester. Range 1..15. Used only with `UART_ARB_LOCK_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst_`  in  1  reset; asynchronous, active-low.
- `mN_req_i`  in  1  transfer request (N = 0, 1).
- `mN_write_i`  in  1  1 = write, 0 = read.
- `mN_addr_i`  in  4  register word address.
- `mN_wdata_i`  in  DATA_W  write data.
- `mN_lock_i`  in  1  requests the next grant as well.
- `mN_gnt_o`  out  1  one-cycle pulse: the transfer has been captured.
- `mN_done_o`  out  1  one-cycle pulse: the transfer is complete.
- `mN_rdata_o`  out  DATA_W  read data. Valid while `mN_done_o` is high; held until the next read done on the same port.
- `paddr_o`  out  4  APB address.
- `pwdata_o`  out  DATA_W  APB write data.
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB control.
- `prdata_i`  in  DATA_W  APB read data from the slave.
- `busy_o`  out  1  high in SETUP and ACCESS.

## Operation
- State machine: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- Arbitration happens only in IDLE and DONE.
  - If any `req` is sampled high in one of those states, the winner's `write`, `addr` and `wdata` are latched and the next state is SETUP.
  - Otherwise IDLE→IDLE, and DONE→IDLE.
- SETUP: `psel_o=1`, `penable_o=0`, winner's `gnt` pulses. Always goes to ACCESS.
- ACCESS: `psel_o=1`, `penable_o=1`. `prdata_i` is sampled at the end of this cycle, because the slave registers read data on the setup edge. Always goes to DONE.
- DONE: `psel_o=0`, `penable_o=0`, winner's `done` pulses. `rdata` updates on reads only; writes leave it unchanged.
- Round-robin rule:
  - `last` register resets to 1, so port 0 wins the first tie.
  - On simultaneous requests, the port other than `last` wins.
  - A single request always wins.
  - `last` updates to the winner at every grant.
- Request rule:
  - `req` is ignored during SETUP and ACCESS.
  - A requester drops `req` by the cycle after `gnt`. Any `req` still high in DONE is a new request.
  - Request fields must stay stable until `gnt`.
- `paddr_o`, `pwrite_o` and `pwdata_o` hold the latched values from SETUP through DONE and keep those values in IDLE.
- Reset values: all outputs 0, state IDLE, `last`=1, lock counter 0.
- Asynchronous reset in any state drops `psel_o`/`penable_o` immediately. No `done` is issued for the aborted transfer.

## Timing
- Request sampled at edge 0 (IDLE): SETUP in cycle 1, ACCESS in cycle 2, DONE with `done`/`rdata` in cycle 3.
- Back-to-back: a request present in DONE starts SETUP in the next cycle. Peak throughput is one transfer per 3 cycles.
- Worst-case wait for a non-locking requester: one transfer of the other port, without `UART_ARB_LOCK_EN`.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - In DONE, if the current owner has `lock_i=1` and `req_i=1`, it wins again regardless of the other request, while the lock counter < `LOCK_MAX`-1. Each such re-grant increments the counter.
  - When the counter reaches the limit, or on any grant to the other port, the counter clears and normal round-robin applies.
  - A locking owner with no `req` releases the lock.
- Undefined: `lock_i` is ignored, the lock counter is absent, and arbitration is pure round-robin.

## Test plan
- m0 read, addr 7, slave returns 0x0000_000A on the setup edge → `psel_o` high in cycles 1–2, `penable_o` high in cycle 2 only, `m0_done_o` in cycle 3 with `m0_rdata_o`=0x0000_000A.
- m1 write, addr 0, wdata 0x55 → `pwrite_o`=1, `pwdata_o`=0x55 from SETUP to DONE; `m1_rdata_o` unchanged.
- Both ports request continuously, 6 transfers, first edge from reset → grant order 0,1,0,1,0,1; one transfer per 3 cycles.
- With `UART_ARB_LOCK_EN`, `LOCK_MAX`=4: m0 lock+req held for 6 transfers, m1 req held → grants 0,0,0,0,1,0.
- Same stimulus without the macro → grants 0,1,0,1,0,1.
- `rst_` low during ACCESS → `psel_o`/`penable_o` go 0 without waiting for a clock, no `done`; after release, the first tie is granted to port 0.
